// File: rtl/snn_spi_config_master_if.sv
// Byte-level handshake between the harness controller and the
// SPI config master of the SNN core.
interface snn_spi_config_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       last;
    logic       abort;
    logic       tx_ready;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output start, tx_data, last, abort,
        input  tx_ready, busy, rx_data, rx_valid
    );

    modport slave (
        input  start, tx_data, last, abort,
        output tx_ready, busy, rx_data, rx_valid
    );
endinterface

// File: rtl/snn_spi_config_master.sv
// Mode-0 SPI initiator, MSB first, 8-bit frames, used to load and
// read back SNN core configuration over a byte handshake.
module snn_spi_config_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    snn_spi_config_master_if.slave host,
    output logic                   sclk,
    output logic                   mosi,
    output logic                   cs_n,
    input  logic                   miso
);
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] TAIL_LAST = 8'(CLK_DIV);
    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_TAIL, S_WAIT, S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] fall_q, fall_d;
    logic [6:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       last_q, last_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       cs_q, cs_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rxv_q, rxv_d;
    logic       rdy_q, rdy_d;
    logic       busy_q, busy_d;
    logic       load;
    logic       abortable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fall_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        fall_d    = fall_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        last_d    = last_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        rxd_d     = rxd_q;
        rxv_d     = 1'b0;
        load      = 1'b0;
        abortable = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                load   = host.start;
            end
            S_WAIT: begin
                cnt_d     = '0;
                abortable = 1'b1;
                load      = host.start && !host.abort;
            end
            S_SETUP: begin
                abortable = 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], miso};
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                abortable = 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (fall_q == 3'd7) begin
                            rxd_d   = rx_q;
                            rxv_d   = 1'b1;
                            state_d = S_TAIL;
                        end else begin
                            fall_d = fall_q + 3'd1;
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[5:0], 1'b0};
                        end
                    end
                end
            end
            S_TAIL: begin
                abortable = 1'b1;
                if (cnt_q == TAIL_LAST) begin
                    cnt_d   = '0;
                    cs_d    = last_q;
                    state_d = last_q ? S_GAP : S_WAIT;
                end
            end
            S_GAP: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh byte: cs_n drops (or stays low) and bit 7 goes out.
        if (load) begin
            tx_d    = host.tx_data[6:0];
            last_d  = host.last;
            mosi_d  = host.tx_data[7];
            cnt_d   = '0;
            fall_d  = '0;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            state_d = S_SETUP;
        end
        if (abortable && host.abort) begin
            cnt_d   = '0;
            sclk_d  = 1'b0;
            cs_d    = 1'b1;
            rxv_d   = 1'b0;
            rxd_d   = rxd_q;
            state_d = S_GAP;
        end
    end

    assign rdy_d  = (state_d == S_IDLE) || (state_d == S_WAIT);
    assign busy_d = (state_d != S_IDLE);

    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign cs_n          = cs_q;
    assign host.tx_ready = rdy_q;
    assign host.busy     = busy_q;
    assign host.rx_data  = rxd_q;
    assign host.rx_valid = rxv_q;
endmodule

// File: tb/tb_snn_spi_config_master.sv
// Directed bench for snn_spi_config_master with a loopback path and
// a mode-0 SPI target model on miso.
module tb_snn_spi_config_master;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 4;

    typedef struct {
        int         cyc;
        logic [4:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       loop_mode;
    logic [7:0] tgt_byte;
    logic [2:0] tgt_bit = 3'd7;
    logic [7:0] mosi_sr = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cs_glitch = 0;
    int         nrxv;
    int         bad;
    bit         ok;
    logic [4:0] tr_flags [0:63];
    logic [7:0] tr_rxd [0:63];
    vec_t       lb_tab [14];

    snn_spi_config_master_if bus ();

    snn_spi_config_master #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .host (bus),
        .sclk (sclk),
        .mosi (mosi),
        .cs_n (cs_n),
        .miso (miso)
    );

    always #5 clk = ~clk;

    // Mode-0 target: bit 7 ready at cs_n low, next bit after each fall.
    assign miso = loop_mode ? mosi : tgt_byte[tgt_bit];

    always @(negedge sclk or posedge cs_n)
        if (cs_n) tgt_bit <= 3'd7;
        else      tgt_bit <= tgt_bit - 3'd1;

    always @(posedge sclk) mosi_sr <= {mosi_sr[6:0], mosi};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] d, input logic l);
        bus.start   = 1'b1;
        bus.tx_data = d;
        bus.last    = l;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        bus.last    = 1'b0;
    endtask

    task automatic do_trace(input int ncyc, input int abort_at,
                            input int istart_at, output int nv);
        nv = 0;
        for (int n = 1; n <= ncyc; n++) begin
            tr_flags[n] = {cs_n, sclk, bus.rx_valid, bus.busy, bus.tx_ready};
            tr_rxd[n]   = bus.rx_data;
            if (bus.rx_valid) nv++;
            bus.abort   = (n == abort_at);
            bus.start   = (n == istart_at);
            bus.tx_data = (n == istart_at) ? 8'hFF : 8'h00;
            @(posedge clk);
            #1;
        end
        bus.abort   = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
    endtask

    // which: 0 = rx_valid, 1 = tx_ready, 2 = busy low
    task automatic wait_for(input int which, input int max_cyc,
                            output bit hit);
        hit = 1'b0;
        for (int n = 0; n < max_cyc && !hit; n++) begin
            if (which == 0 && bus.rx_valid === 1'b1) hit = 1'b1;
            if (which == 1 && bus.tx_ready === 1'b1) hit = 1'b1;
            if (which == 2 && bus.busy === 1'b0) hit = 1'b1;
            if (!hit) begin
                if (which < 2 && cs_n !== 1'b0) cs_glitch++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        // {cs_n, sclk, rx_valid, busy, tx_ready} per cycle
        lb_tab[0]  = '{1,  5'b00010};
        lb_tab[1]  = '{2,  5'b00010};
        lb_tab[2]  = '{3,  5'b01010};
        lb_tab[3]  = '{4,  5'b01010};
        lb_tab[4]  = '{5,  5'b00010};
        lb_tab[5]  = '{11, 5'b01010};
        lb_tab[6]  = '{31, 5'b01010};
        lb_tab[7]  = '{32, 5'b01010};
        lb_tab[8]  = '{33, 5'b00110};
        lb_tab[9]  = '{34, 5'b00010};
        lb_tab[10] = '{35, 5'b00010};
        lb_tab[11] = '{36, 5'b10010};
        lb_tab[12] = '{39, 5'b10010};
        lb_tab[13] = '{40, 5'b10001};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        bus.last    = 1'b0;
        bus.abort   = 1'b0;
        loop_mode   = 1'b1;
        tgt_byte    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Loopback single byte, cycle-exact table
        launch(8'hA5, 1'b1);
        do_trace(44, 0, 0, nrxv);
        for (int i = 0; i < 14; i++)
            chk($sformatf("lb_cyc%0d", lb_tab[i].cyc),
                32'(tr_flags[lb_tab[i].cyc]), 32'(lb_tab[i].exp));
        chk("lb_rx_data", 32'(tr_rxd[33]), 32'hA5);
        chk("lb_rx_valid_count", 32'(nrxv), 32'd1);
        chk("lb_mosi_stream", 32'(mosi_sr), 32'hA5);

        // Multi-byte against the target model
        loop_mode = 1'b0;
        tgt_byte  = 8'h81;
        cs_glitch = 0;
        launch(8'h3C, 1'b0);
        wait_for(0, 200, ok);
        chk("mb0_rx_valid_seen", 32'(ok), 32'd1);
        chk("mb0_rx_data", 32'(bus.rx_data), 32'h81);
        chk("mb0_mosi_stream", 32'(mosi_sr), 32'h3C);
        wait_for(1, 200, ok);
        chk("mb_wait_seen", 32'(ok), 32'd1);
        chk("mb_wait_flags", 32'({cs_n, sclk, bus.busy, bus.tx_ready}),
            32'b0011);
        tgt_byte = 8'h7E;
        launch(8'hF0, 1'b1);
        wait_for(0, 200, ok);
        chk("mb1_rx_valid_seen", 32'(ok), 32'd1);
        chk("mb1_rx_data", 32'(bus.rx_data), 32'h7E);
        chk("mb1_mosi_stream", 32'(mosi_sr), 32'hF0);
        chk("mb_cs_held_low", 32'(cs_glitch), 32'd0);
        wait_for(2, 200, ok);
        chk("mb_back_idle", 32'(ok), 32'd1);
        @(posedge clk);
        #1;

        // Abort after the 5th sclk edge
        loop_mode = 1'b1;
        launch(8'h33, 1'b1);
        do_trace(24, 11, 0, nrxv);
        chk("ab_cyc11", 32'(tr_flags[11]), 32'b01010);
        chk("ab_cyc12", 32'(tr_flags[12]), 32'b10010);
        chk("ab_cyc15", 32'(tr_flags[15]), 32'b10010);
        chk("ab_cyc16", 32'(tr_flags[16]), 32'b10001);
        chk("ab_no_rx_valid", 32'(nrxv), 32'd0);
        chk("ab_rx_data_kept", 32'(tr_rxd[20]), 32'h7E);

        // Start pulse during SHIFT is ignored
        launch(8'h96, 1'b1);
        do_trace(44, 0, 10, nrxv);
        chk("ig_rx_valid_count", 32'(nrxv), 32'd1);
        chk("ig_cyc33", 32'(tr_flags[33]), 32'b00110);
        chk("ig_rx_data", 32'(tr_rxd[33]), 32'h96);
        chk("ig_mosi_stream", 32'(mosi_sr), 32'h96);
        chk("ig_cyc40", 32'(tr_flags[40]), 32'b10001);

        // Reset in the middle of SHIFT
        launch(8'hF3, 1'b1);
        do_trace(10, 0, 0, nrxv);
        chk("mr_pre_mosi", 32'(mosi), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mr_cs_n", 32'(cs_n), 32'd1);
        chk("mr_sclk", 32'(sclk), 32'd0);
        chk("mr_mosi", 32'(mosi), 32'd0);
        chk("mr_rx_data", 32'(bus.rx_data), 32'h00);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        launch(8'h55, 1'b1);
        do_trace(44, 0, 0, nrxv);
        chk("mr_new_rx_data", 32'(tr_rxd[33]), 32'h55);
        chk("mr_new_rx_valid_count", 32'(nrxv), 32'd1);
        chk("mr_new_cyc40", 32'(tr_flags[40]), 32'b10001);

        // Hold WAIT for 100 cycles, then finish with last=1
        launch(8'hC3, 1'b0);
        wait_for(1, 200, ok);
        chk("wh_wait_seen", 32'(ok), 32'd1);
        chk("wh_rx_data", 32'(bus.rx_data), 32'hC3);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (cs_n !== 1'b0 || sclk !== 1'b0 ||
                bus.tx_ready !== 1'b1 || bus.busy !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        chk("wh_hold_bad_cycles", 32'(bad), 32'd0);
        launch(8'h3C, 1'b1);
        do_trace(44, 0, 0, nrxv);
        chk("wh_cyc1", 32'(tr_flags[1]), 32'b00010);
        chk("wh_cyc3", 32'(tr_flags[3]), 32'b01010);
        chk("wh_rx_data2", 32'(tr_rxd[33]), 32'h3C);
        chk("wh_cyc36", 32'(tr_flags[36]), 32'b10010);
        chk("wh_cyc40", 32'(tr_flags[40]), 32'b10001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
